// File: rtl/pcie_tx_arbiter.sv
// Credit-gated round-robin arbiter sharing the PCIe VC0 TX port between two TLP requesters.
// tx_req one cycle after an eligible request; grant same cycle as tx_rdy; XFER mux adds no latency; ineligible requesters wait.
module pcie_tx_arbiter (
  input  logic        pcie_clk,
  input  logic        sys_rst,
  input  logic        r0_req,
  input  logic        r0_posted,
  input  logic [9:0]  r0_dlen,
  output logic        r0_gnt,
  input  logic        r0_st,
  input  logic        r0_end,
  input  logic [15:0] r0_data,
  input  logic        r1_req,
  input  logic        r1_posted,
  input  logic [9:0]  r1_dlen,
  output logic        r1_gnt,
  input  logic        r1_st,
  input  logic        r1_end,
  input  logic [15:0] r1_data,
  output logic        tx_req,
  input  logic        tx_rdy,
  output logic        tx_st,
  output logic        tx_end,
  output logic [15:0] tx_data,
  input  logic [8:0]  tx_ca_ph,
  input  logic [8:0]  tx_ca_cplh,
  input  logic [12:0] tx_ca_pd,
  input  logic [12:0] tx_ca_cpld,
  input  logic        tx_ca_p_recheck,
  input  logic        tx_ca_cpl_recheck
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } state_t;

  typedef struct packed {
    logic       sel;
    logic       posted;
    logic [8:0] dc;
  } pick_t;

  state_t state, state_nxt;
  pick_t  pick, pick_nxt;
  logic   last, last_nxt;

  logic [8:0] r0_dc, r1_dc;
  logic       r0_elig, r1_elig;
  logic       win;
  logic       sel_ok;
  logic       recheck;

  function automatic logic [8:0] data_credits(input logic [9:0] dlen);
    logic [10:0] sum;
    sum = {1'b0, dlen} + 11'd3;
    return sum[10:2];
  endfunction

  // Credit MSB set means the core advertises infinite credit of that type.
  function automatic logic credit_ok(input logic [8:0] hc, input logic [12:0] dcr,
                                     input logic [8:0] need);
    return (hc[8] | (hc[7:0] >= 8'd1)) & (dcr[12] | (dcr[11:0] >= {3'b000, need}));
  endfunction

  assign r0_dc = data_credits(r0_dlen);
  assign r1_dc = data_credits(r1_dlen);

  assign r0_elig = r0_req & (r0_posted ? credit_ok(tx_ca_ph, tx_ca_pd, r0_dc)
                                       : credit_ok(tx_ca_cplh, tx_ca_cpld, r0_dc));
  assign r1_elig = r1_req & (r1_posted ? credit_ok(tx_ca_ph, tx_ca_pd, r1_dc)
                                       : credit_ok(tx_ca_cplh, tx_ca_cpld, r1_dc));

  assign win = (r0_elig & r1_elig) ? ~last : r1_elig;

  // Re-evaluation uses the class and data credits latched when the TLP was picked.
  assign sel_ok  = (pick.sel ? r1_req : r0_req) &
                   (pick.posted ? credit_ok(tx_ca_ph, tx_ca_pd, pick.dc)
                                : credit_ok(tx_ca_cplh, tx_ca_cpld, pick.dc));
  assign recheck = pick.posted ? tx_ca_p_recheck : tx_ca_cpl_recheck;

  always_ff @(posedge pcie_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
      pick  <= '0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      pick  <= pick_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pick_nxt  = pick;
    last_nxt  = last;
    tx_req    = 1'b0;
    r0_gnt    = 1'b0;
    r1_gnt    = 1'b0;
    tx_st     = 1'b0;
    tx_end    = 1'b0;
    tx_data   = '0;
    case (state)
      IDLE: begin
        if (r0_elig | r1_elig) begin
          pick_nxt.sel    = win;
          pick_nxt.posted = win ? r1_posted : r0_posted;
          pick_nxt.dc     = win ? r1_dc : r0_dc;
          state_nxt       = REQ;
        end
      end
      REQ: begin
        tx_req = 1'b1;
        if (tx_rdy) begin
          r0_gnt    = ~pick.sel;
          r1_gnt    = pick.sel;
          last_nxt  = pick.sel;
          state_nxt = XFER;
        end else if (recheck && !sel_ok) begin
          state_nxt = IDLE;
        end
      end
      XFER: begin
        tx_st   = pick.sel ? r1_st : r0_st;
        tx_end  = pick.sel ? r1_end : r0_end;
        tx_data = pick.sel ? r1_data : r0_data;
        if (pick.sel ? r1_end : r0_end) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Bench for pcie_tx_arbiter: requester agents, a credit/round-robin reference model and directed plus random stimulus.
module tb_pcie_tx_arbiter;
  logic        pcie_clk = 1'b0;
  logic        sys_rst  = 1'b0;
  logic        r0_req, r0_posted, r0_gnt, r0_st, r0_end;
  logic [9:0]  r0_dlen;
  logic [15:0] r0_data;
  logic        r1_req, r1_posted, r1_gnt, r1_st, r1_end;
  logic [9:0]  r1_dlen;
  logic [15:0] r1_data;
  logic        tx_req, tx_rdy, tx_st, tx_end;
  logic [15:0] tx_data;
  logic [8:0]  tx_ca_ph, tx_ca_cplh;
  logic [12:0] tx_ca_pd, tx_ca_cpld;
  logic        tx_ca_p_recheck, tx_ca_cpl_recheck;

  pcie_tx_arbiter dut (
    .pcie_clk(pcie_clk), .sys_rst(sys_rst),
    .r0_req(r0_req), .r0_posted(r0_posted), .r0_dlen(r0_dlen), .r0_gnt(r0_gnt),
    .r0_st(r0_st), .r0_end(r0_end), .r0_data(r0_data),
    .r1_req(r1_req), .r1_posted(r1_posted), .r1_dlen(r1_dlen), .r1_gnt(r1_gnt),
    .r1_st(r1_st), .r1_end(r1_end), .r1_data(r1_data),
    .tx_req(tx_req), .tx_rdy(tx_rdy), .tx_st(tx_st), .tx_end(tx_end), .tx_data(tx_data),
    .tx_ca_ph(tx_ca_ph), .tx_ca_cplh(tx_ca_cplh), .tx_ca_pd(tx_ca_pd), .tx_ca_cpld(tx_ca_cpld),
    .tx_ca_p_recheck(tx_ca_p_recheck), .tx_ca_cpl_recheck(tx_ca_cpl_recheck)
  );

  always #4 pcie_clk = ~pcie_clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge pcie_clk) cyc <= cyc + 1;

  // Requester agents: a_* is the pending TLP, s_* the stream in flight after a grant.
  int a_left[2];
  bit a_post[2];
  int a_dlen[2];
  bit a_rand[2];
  bit s_on[2];
  int s_idx[2];
  int s_len[2];
  bit g_seen[2];

  // Reference model: 0 idle, 1 requesting the core, 2 transferring.
  int m_phase = 0;
  int m_owner = 0;
  int m_last  = 1;
  bit m_cls;
  int m_need;
  bit e0, e1;

  int g_who[$], g_cyc[$], rise_cyc[$], end_cyc[$], wlen[$];
  bit prev_req = 0;
  bit in_pkt = 0;
  int cur_words = 0;
  int t0;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int m_dc(input int dlen);
    return (dlen + 3) / 4;
  endfunction

  function automatic bit m_ok(input bit posted, input int need);
    int h, d;
    h = posted ? int'(tx_ca_ph) : int'(tx_ca_cplh);
    d = posted ? int'(tx_ca_pd) : int'(tx_ca_cpld);
    return (h >= 256 || h % 256 >= 1) && (d >= 4096 || d % 4096 >= need);
  endfunction

  function automatic bit p_req(input int n);  return (n == 0) ? r0_req : r1_req; endfunction
  function automatic bit p_post(input int n); return (n == 0) ? r0_posted : r1_posted; endfunction
  function automatic int p_dlen(input int n); return (n == 0) ? int'(r0_dlen) : int'(r1_dlen); endfunction
  function automatic bit p_st(input int n);   return (n == 0) ? r0_st : r1_st; endfunction
  function automatic bit p_end(input int n);  return (n == 0) ? r0_end : r1_end; endfunction
  function automatic logic [15:0] p_data(input int n); return (n == 0) ? r0_data : r1_data; endfunction

  function automatic bit m_elig(input int n);
    return p_req(n) && m_ok(p_post(n), m_dc(p_dlen(n)));
  endfunction

  always @(negedge pcie_clk) begin
    if (sys_rst) begin
      chk("rst_tx_req", tx_req, 0);
      chk("rst_gnt", {r1_gnt, r0_gnt}, 0);
      chk("rst_tx_st", tx_st, 0);
      chk("rst_tx_end", tx_end, 0);
      chk("rst_tx_data", tx_data, 0);
      m_phase = 0; m_last = 1; m_owner = 0; prev_req = 0; in_pkt = 0;
    end else begin
      chk("tx_req", tx_req, m_phase == 1);
      chk("r0_gnt", r0_gnt, m_phase == 1 && tx_rdy && m_owner == 0);
      chk("r1_gnt", r1_gnt, m_phase == 1 && tx_rdy && m_owner == 1);
      chk("tx_st", tx_st, (m_phase == 2) ? p_st(m_owner) : 1'b0);
      chk("tx_end", tx_end, (m_phase == 2) ? p_end(m_owner) : 1'b0);
      chk("tx_data", tx_data, (m_phase == 2) ? p_data(m_owner) : 16'h0);
      if (tx_req && !prev_req) rise_cyc.push_back(cyc);
      prev_req = tx_req;
      if (r0_gnt) begin g_who.push_back(0); g_cyc.push_back(cyc); end
      if (r1_gnt) begin g_who.push_back(1); g_cyc.push_back(cyc); end
      if (tx_st) begin in_pkt = 1; cur_words = 0; end
      if (in_pkt) cur_words++;
      if (tx_end && in_pkt) begin
        in_pkt = 0; end_cyc.push_back(cyc); wlen.push_back(cur_words);
      end
      case (m_phase)
        0: begin
          e0 = m_elig(0);
          e1 = m_elig(1);
          if (e0 || e1) begin
            m_owner = (e0 && e1) ? 1 - m_last : (e0 ? 0 : 1);
            m_cls   = p_post(m_owner);
            m_need  = m_dc(p_dlen(m_owner));
            m_phase = 1;
          end
        end
        1: begin
          if (tx_rdy) begin
            m_last = m_owner; m_phase = 2;
          end else if ((m_cls ? tx_ca_p_recheck : tx_ca_cpl_recheck) &&
                       !(p_req(m_owner) && m_ok(m_cls, m_need))) begin
            m_phase = 0;
          end
        end
        default: if (p_end(m_owner)) m_phase = 0;
      endcase
    end
    g_seen[0] = r0_gnt;
    g_seen[1] = r1_gnt;
  end

  task automatic new_params(input int n);
    a_post[n] = 1'($urandom);
    a_dlen[n] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
  endtask

  task automatic rand_credits();
    tx_ca_ph   = ($urandom_range(0, 7) == 0) ? (9'h100 | 9'($urandom_range(0, 255))) : 9'($urandom_range(0, 3));
    tx_ca_cplh = ($urandom_range(0, 7) == 0) ? (9'h100 | 9'($urandom_range(0, 255))) : 9'($urandom_range(0, 3));
    tx_ca_pd   = ($urandom_range(0, 7) == 0) ? (13'h1000 | 13'($urandom_range(0, 4095))) : 13'($urandom_range(0, 12));
    tx_ca_cpld = ($urandom_range(0, 7) == 0) ? (13'h1000 | 13'($urandom_range(0, 4095))) : 13'($urandom_range(0, 12));
  endtask

  // Idle requesters drive noise on st/end/data; the arbiter must ignore it.
  task automatic agent_pins(input int n, output logic st, output logic en, output logic [15:0] d);
    if (s_on[n]) begin
      st = (s_idx[n] == 0);
      en = (s_idx[n] == s_len[n] - 1);
    end else begin
      st = 1'($urandom);
      en = 1'($urandom);
    end
    d = 16'($urandom);
  endtask

  task automatic drive_agents();
    r0_req = (a_left[0] > 0); r0_posted = a_post[0]; r0_dlen = 10'(a_dlen[0]);
    r1_req = (a_left[1] > 0); r1_posted = a_post[1]; r1_dlen = 10'(a_dlen[1]);
    agent_pins(0, r0_st, r0_end, r0_data);
    agent_pins(1, r1_st, r1_end, r1_data);
  endtask

  task automatic tick();
    @(posedge pcie_clk);
    #1;
    for (int n = 0; n < 2; n++) begin
      if (s_on[n]) begin
        s_idx[n]++;
        if (s_idx[n] == s_len[n]) s_on[n] = 0;
      end
      if (g_seen[n]) begin
        s_on[n] = 1; s_idx[n] = 0; s_len[n] = 8 + 2 * a_dlen[n];
        if (a_left[n] > 0) a_left[n]--;
        if (a_rand[n]) new_params(n);
      end
    end
    drive_agents();
  endtask

  task automatic clear_logs();
    g_who.delete(); g_cyc.delete(); rise_cyc.delete(); end_cyc.delete(); wlen.delete();
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    a_left = '{0, 0}; a_rand = '{0, 0}; s_on = '{0, 0};
    tx_rdy = 0; tx_ca_ph = 0; tx_ca_cplh = 0; tx_ca_pd = 0; tx_ca_cpld = 0;
    tx_ca_p_recheck = 0; tx_ca_cpl_recheck = 0;
    drive_agents();
    repeat (2) @(posedge pcie_clk);
    #1;
    sys_rst = 1'b0;
    clear_logs();
  endtask

  task automatic wait_req(input int lim, input string name);
    bit ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      tick();
      ok = tx_req;
    end
    chk(name, ok, 1);
  endtask

  task automatic wait_grants(input int n, input int lim, input string name);
    bit ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      tick();
      ok = (g_who.size() >= n);
    end
    chk(name, ok, 1);
  endtask

  task automatic wait_ends(input int n, input int lim, input string name);
    bit ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      tick();
      ok = (end_cyc.size() >= n);
    end
    chk(name, ok, 1);
  endtask

  initial begin
    a_left = '{0, 0}; a_post = '{0, 0}; a_dlen = '{0, 0}; a_rand = '{0, 0};
    s_on = '{0, 0}; s_idx = '{0, 0}; s_len = '{0, 0}; g_seen = '{0, 0};
    tx_rdy = 0; tx_ca_ph = 0; tx_ca_cplh = 0; tx_ca_pd = 0; tx_ca_cpld = 0;
    tx_ca_p_recheck = 0; tx_ca_cpl_recheck = 0;
    drive_agents();
    #2;

    chk("model_dc_0", m_dc(0), 0);
    chk("model_dc_4", m_dc(4), 1);
    chk("model_dc_5", m_dc(5), 2);
    chk("model_dc_16", m_dc(16), 4);
    chk("model_dc_1023", m_dc(1023), 256);

    // Single posted requester, core stalls three REQ cycles.
    do_reset();
    tx_ca_ph = 9'd4; tx_ca_pd = 13'd8;
    a_left[1] = 1; a_post[1] = 1; a_dlen[1] = 32;
    drive_agents();
    t0 = cyc;
    wait_req(10, "t1_req_wait");
    tick();
    tick();
    tick();
    tx_rdy = 1;
    tick();
    tx_rdy = 0;
    wait_ends(1, 150, "t1_end_wait");
    tick();
    chk("t1_req_latency", (rise_cyc.size() > 0) ? rise_cyc[0] - t0 : -1, 1);
    chk("t1_gnt_who", (g_who.size() > 0) ? g_who[0] : -1, 1);
    chk("t1_gnt_delay", (g_cyc.size() > 0 && rise_cyc.size() > 0) ? g_cyc[0] - rise_cyc[0] : -1, 3);
    chk("t1_words", (wlen.size() > 0) ? wlen[0] : -1, 72);
    chk("t1_end_cycle", (end_cyc.size() > 0 && g_cyc.size() > 0) ? end_cyc[0] - g_cyc[0] : -1, 72);
    chk("t1_idle_after", tx_req, 0);

    // Round-robin with both requesters continuously pending.
    do_reset();
    tx_ca_ph = 9'd50; tx_ca_cplh = 9'd50; tx_ca_pd = 13'd500; tx_ca_cpld = 13'd500; tx_rdy = 1;
    a_left = '{2, 2}; a_post = '{1, 0}; a_dlen = '{3, 2};
    drive_agents();
    wait_ends(4, 200, "t2_end_wait");
    for (int k = 0; k < 4; k++)
      chk($sformatf("t2_order%0d", k), (g_who.size() > k) ? g_who[k] : -1, k % 2);
    for (int k = 0; k < 3; k++)
      chk($sformatf("t2_gap%0d", k),
          (rise_cyc.size() > k + 1 && end_cyc.size() > k) ? rise_cyc[k + 1] - end_cyc[k] : -1, 2);

    // Posted requester blocked on data credit while completion proceeds.
    do_reset();
    tx_ca_ph = 9'd4; tx_ca_pd = 13'd3; tx_ca_cplh = 9'd4; tx_ca_cpld = 13'd10; tx_rdy = 1;
    a_left = '{1, 1}; a_post = '{1, 0}; a_dlen = '{16, 4};
    drive_agents();
    repeat (40) tick();
    chk("t3_grant_count", g_who.size(), 1);
    chk("t3_first_who", (g_who.size() > 0) ? g_who[0] : -1, 1);
    tx_ca_pd = 13'd4;
    wait_grants(2, 20, "t3_second_wait");
    chk("t3_second_who", (g_who.size() > 1) ? g_who[1] : -1, 0);
    wait_ends(2, 60, "t3_end_wait");

    // Infinite posted data credit with the largest payload.
    do_reset();
    tx_ca_ph = 9'd1; tx_ca_pd = 13'h1000; tx_rdy = 1;
    a_left[0] = 1; a_post[0] = 1; a_dlen[0] = 1023;
    drive_agents();
    wait_ends(1, 2200, "t4_end_wait");
    chk("t4_gnt_who", (g_who.size() > 0) ? g_who[0] : -1, 0);
    chk("t4_words", (wlen.size() > 0) ? wlen[0] : -1, 2054);

    // Recheck behaviour while waiting in REQ.
    do_reset();
    tx_ca_ph = 9'd2; tx_ca_pd = 13'd2;
    a_left[1] = 1; a_post[1] = 1; a_dlen[1] = 8;
    drive_agents();
    wait_req(10, "t5_req_wait");
    tx_ca_p_recheck = 1;
    tick();
    tx_ca_p_recheck = 0;
    chk("t5_hold_req", tx_req, 1);
    tx_ca_pd = 13'd1;
    tx_ca_p_recheck = 1;
    tick();
    tx_ca_p_recheck = 0;
    chk("t5_drop_req", tx_req, 0);
    repeat (5) tick();
    chk("t5_still_idle", tx_req, 0);
    chk("t5_no_grant", g_who.size(), 0);
    tx_ca_pd = 13'd2;
    wait_req(10, "t5_req_wait2");
    tx_ca_pd = 13'd1;
    tx_ca_cpl_recheck = 1;
    tick();
    tx_ca_cpl_recheck = 0;
    chk("t5_other_class", tx_req, 1);
    tx_ca_p_recheck = 1;
    tx_rdy = 1;
    tick();
    tx_ca_p_recheck = 0;
    tx_rdy = 0;
    chk("t5_rdy_wins", g_who.size(), 1);
    wait_ends(1, 60, "t5_end_wait");

    // Asynchronous reset in the middle of a transfer, then tie-break restart.
    do_reset();
    tx_ca_ph = 9'd50; tx_ca_cplh = 9'd50; tx_ca_pd = 13'd500; tx_ca_cpld = 13'd500; tx_rdy = 1;
    a_left[0] = 1; a_post[0] = 1; a_dlen[0] = 16;
    drive_agents();
    wait_grants(1, 10, "t6_gnt_wait");
    repeat (4) tick();
    chk("t6_mid_xfer", in_pkt, 1);
    #2;
    sys_rst = 1'b1;
    r0_st = 1; r0_end = 1; r0_data = 16'hA5A5;
    a_left = '{0, 0}; s_on = '{0, 0};
    #1;
    chk("t6_async_tx_st", tx_st, 0);
    chk("t6_async_tx_end", tx_end, 0);
    chk("t6_async_tx_data", tx_data, 0);
    chk("t6_async_tx_req", tx_req, 0);
    chk("t6_async_gnt", {r1_gnt, r0_gnt}, 0);
    tick();
    tick();
    sys_rst = 1'b0;
    clear_logs();
    a_left = '{1, 1}; a_post = '{1, 1}; a_dlen = '{2, 2};
    drive_agents();
    wait_grants(1, 10, "t6_tie_wait");
    chk("t6_tie_r0", (g_who.size() > 0) ? g_who[0] : -1, 0);
    wait_ends(2, 80, "t6_end_wait");

    // Randomised traffic, credits, stalls and rechecks.
    do_reset();
    a_rand = '{1, 1}; a_left = '{40, 40};
    new_params(0);
    new_params(1);
    rand_credits();
    drive_agents();
    repeat (4000) begin
      tick();
      tx_rdy = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 7) == 0) rand_credits();
      tx_ca_p_recheck   = ($urandom_range(0, 5) == 0);
      tx_ca_cpl_recheck = ($urandom_range(0, 5) == 0);
    end
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
